// File: rtl/instr_loader_pkg.sv
// Shared types for the instruction loader: opcodes, operand fields, FSM states.
// Optional build macro INSTR_LOADER_CHECKSUM_EN is consumed by instr_loader.
package instr_loader_pkg;

  localparam int OP_W  = 6;
  localparam int REG_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_type;

  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] shamt;
    logic [5:0]       funct;
    logic [15:0]      imm;
    logic [25:0]      target;
  } instr_fields_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } loader_state_t;

endpackage

// File: rtl/instr_loader_encoder.sv
// Packs an opcode plus operand fields into a 32-bit MIPS word.
// legal is low for any opcode outside the supported set.
module instr_encoder
  import instr_loader_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  instr_fields_t   f,
  output logic [31:0]     word,
  output logic            legal
);

  logic is_r;
  logic is_j;
  logic is_i;

  assign is_r = (op == OP_RTYPE);
  assign is_j = (op == OP_J);
  assign is_i = (op == OP_LW)  || (op == OP_SW)  ||
                (op == OP_BEQ) || (op == OP_BNE) ||
                (op == OP_ADDI);

  // Select the R/I/J field layout for the opcode class.
  always_comb begin
    word  = '0;
    legal = 1'b0;
    unique case (1'b1)
      is_r: begin
        word  = {op, f.rs, f.rt, f.rd,
                 f.shamt, f.funct};
        legal = 1'b1;
      end
      is_j: begin
        word  = {op, f.target};
        legal = 1'b1;
      end
      is_i: begin
        word  = {op, f.rs, f.rt, f.imm};
        legal = 1'b1;
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// Streams field-level descriptors into sequential imem writes.
// Define INSTR_LOADER_CHECKSUM_EN to add a running XOR checksum output.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [REG_W-1:0]  in_rs,
  input  logic [REG_W-1:0]  in_rt,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [REG_W-1:0]  in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              err_illegal
`ifdef INSTR_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] TOP  = '1;

  loader_state_t     state;
  logic [ADDR_W-1:0] cnt;
  instr_fields_t     fields;
  logic [31:0]       word;
  logic              legal;
  logic              hs;
  logic              at_top;

  assign fields.rs     = in_rs;
  assign fields.rt     = in_rt;
  assign fields.rd     = in_rd;
  assign fields.shamt  = in_shamt;
  assign fields.funct  = in_funct;
  assign fields.imm    = in_imm;
  assign fields.target = in_target;

  instr_encoder u_enc (
    .op    (in_op),
    .f     (fields),
    .word  (word),
    .legal (legal)
  );

  assign in_ready = (state == LOAD) && !start;
  assign hs       = in_valid && in_ready;
  assign busy     = (state == LOAD);
  assign at_top   = (cnt == TOP);

  // Session FSM, address counter, write port and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= BASE;
      imem_we     <= 1'b0;
      imem_addr   <= BASE;
      imem_wdata  <= '0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (start) begin
        state       <= LOAD;
        cnt         <= BASE;
        done        <= 1'b0;
        overflow    <= 1'b0;
        err_illegal <= 1'b0;
      end else if (hs) begin
        if (legal) begin
          imem_we    <= 1'b1;
          imem_addr  <= cnt;
          imem_wdata <= word;
          // the last slot is a hard stop: no wrap
          if (!at_top) cnt <= cnt + 1'b1;
          if (in_last || at_top) begin
            state <= DONE;
            done  <= 1'b1;
          end
          if (at_top && !in_last)
            overflow <= 1'b1;
        end else begin
          err_illegal <= 1'b1;
          if (in_last) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
      end
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  // XOR of every word written, updated with the write strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      checksum <= '0;
    else if (start)
      checksum <= '0;
    else if (hs && legal)
      checksum <= checksum ^ word;
  end
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader against a descriptor-level model.
// Checksum checks are active when INSTR_LOADER_CHECKSUM_EN is defined.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_op = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [5:0]  in_funct = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        in_last = 1'b0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy, done, overflow, err_illegal;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  instr_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy),
    .done(done), .overflow(overflow),
    .err_illegal(err_illegal)
`ifdef INSTR_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] tg;
    bit          last;
  } desc_t;

  int checks = 0;
  int failures = 0;

  desc_t       prog[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  bit          exp_err, exp_ovf, exp_done;
  logic [31:0] exp_sum;
  int          n_acc;

  int          got_addr[$];
  logic [31:0] got_data[$];
  int          got_cyc[$];
  int          cyc = 0;
  bit          hs_last = 0;
  int          spurious = 0;

  always @(posedge clk) cyc++;

  // write monitor: every write must follow a handshake one edge earlier
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      got_addr.push_back(int'(imem_addr));
      got_data.push_back(imem_wdata);
      got_cyc.push_back(cyc);
      if (!hs_last) spurious++;
    end
    hs_last = (in_valid === 1'b1) && (in_ready === 1'b1) && !rst;
  end

  function automatic logic [31:0] enc(desc_t d, output bit ok);
    logic [31:0] w;
    ok = 1;
    case (d.op)
      6'h00: w = (32'(d.op) << 26) | (32'(d.rs) << 21) |
                 (32'(d.rt) << 16) | (32'(d.rd) << 11) |
                 (32'(d.sh) << 6) | 32'(d.fn);
      6'h02: w = (32'(d.op) << 26) | 32'(d.tg);
      6'h04, 6'h05, 6'h08, 6'h23, 6'h2B:
        w = (32'(d.op) << 26) | (32'(d.rs) << 21) |
            (32'(d.rt) << 16) | 32'(d.imm);
      default: begin w = 0; ok = 0; end
    endcase
    return w;
  endfunction

  function automatic desc_t mk(logic [5:0] op, logic [4:0] rs,
      logic [4:0] rt, logic [4:0] rd, logic [4:0] sh,
      logic [5:0] fn, logic [15:0] imm, logic [25:0] tg, bit last);
    desc_t d;
    d.op = op; d.rs = rs; d.rt = rt; d.rd = rd; d.sh = sh;
    d.fn = fn; d.imm = imm; d.tg = tg; d.last = last;
    return d;
  endfunction

  // Reference: walk the program, decide which writes happen and where
  task automatic model_run(int cap);
    int a;
    bit ok;
    logic [31:0] w;
    exp_addr.delete(); exp_data.delete();
    exp_err = 0; exp_ovf = 0; exp_done = 0; exp_sum = 0;
    a = 0; n_acc = 0;
    for (int i = 0; i < prog.size(); i++) begin
      n_acc++;
      w = enc(prog[i], ok);
      if (!ok) begin
        exp_err = 1;
        if (prog[i].last) begin exp_done = 1; break; end
      end else begin
        exp_addr.push_back(a);
        exp_data.push_back(w);
        exp_sum ^= w;
        if (prog[i].last) begin exp_done = 1; break; end
        if (a == cap - 1) begin
          exp_ovf = 1; exp_done = 1; break;
        end
        a++;
      end
    end
  endtask

  task automatic drive(desc_t d);
    in_op = d.op; in_rs = d.rs; in_rt = d.rt; in_rd = d.rd;
    in_shamt = d.sh; in_funct = d.fn; in_imm = d.imm;
    in_target = d.tg; in_last = d.last;
  endtask

  task automatic send(desc_t d, int gap);
    bit ok;
    for (int g = 0; g < gap; g++) begin
      in_valid = 0; @(posedge clk); #1;
    end
    drive(d);
    in_valid = 1;
    ok = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout in_ready=%b required=1", in_ready);
      in_valid = 0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic pulse_start();
    got_addr.delete(); got_data.delete(); got_cyc.delete();
    spurious = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic run_prog(int maxgap, int cap);
    model_run(cap);
    pulse_start();
    for (int i = 0; i < n_acc; i++)
      send(prog[i], maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checks++;
    if ({imem_we, busy, done, overflow, err_illegal, in_ready} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b required=000000",
        {imem_we, busy, done, overflow, err_illegal, in_ready});
    end
    checks++;
    if (imem_addr !== 8'd0 || imem_wdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_bus addr=%h data=%h required=0/0",
        imem_addr, imem_wdata);
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    checks++;
    if (checksum !== 32'd0) begin
      failures++;
      $display("FAIL reset_checksum got=%h required=0", checksum);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_program();
    logic [31:0] want[3] = '{32'h20080005, 32'h01095020, 32'h08000010};
    prog.delete();
    prog.push_back(mk(6'h08, 0, 8, 0, 0, 0, 16'd5, 0, 0));
    prog.push_back(mk(6'h00, 8, 9, 10, 0, 6'h20, 0, 0, 0));
    prog.push_back(mk(6'h02, 0, 0, 0, 0, 0, 0, 26'h10, 1));
    run_prog(0, 256);
    checks++;
    if (got_data.size() != 3) begin
      failures++;
      $display("FAIL prog_count got=%0d required=3", got_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_data[i] !== want[i] || got_addr[i] != i) begin
          failures++;
          $display("FAIL prog_word%0d got=%h@%0d required=%h@%0d",
            i, got_data[i], got_addr[i], want[i], i);
        end
      end
      checks++;
      if (got_cyc[2] - got_cyc[0] != 2) begin
        failures++;
        $display("FAIL prog_b2b span=%0d required=2",
          got_cyc[2] - got_cyc[0]);
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL prog_done done=%b busy=%b required=1/0", done, busy);
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    checks++;
    if (checksum !== 32'h29015035) begin
      failures++;
      $display("FAIL prog_checksum got=%h required=29015035", checksum);
    end
`endif
  endtask

  task automatic test_toggle();
    prog.delete();
    prog.push_back(mk(6'h23, 8, 9, 0, 0, 0, 16'd4, 0, 1));
    run_prog(1, 256);
    for (int i = 0; i < 6; i++) begin
      in_valid = ~in_valid; @(posedge clk); #1;
    end
    in_valid = 0;
    @(posedge clk); #1;
    checks++;
    if (got_data.size() != 1 || got_data[0] !== 32'h8D090004 ||
        got_addr[0] != 0) begin
      failures++;
      $display("FAIL toggle_write n=%0d required=1 of 8d090004@0",
        got_data.size());
    end
    checks++;
    if (spurious != 0) begin
      failures++;
      $display("FAIL toggle_spurious got=%0d required=0", spurious);
    end
  endtask

  task automatic test_illegal();
    prog.delete();
    prog.push_back(mk(6'h08, 1, 2, 0, 0, 0, 16'h1234, 0, 0));
    prog.push_back(mk(6'h3F, 3, 3, 3, 3, 3, 16'h5555, 0, 0));
    prog.push_back(mk(6'h08, 3, 4, 0, 0, 0, 16'hFFFF, 0, 1));
    run_prog(0, 256);
    checks++;
    if (got_data.size() != 2 || spurious != 0) begin
      failures++;
      $display("FAIL illegal_count got=%0d required=2", got_data.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_addr[i] != exp_addr[i] || got_data[i] !== exp_data[i]) begin
          failures++;
          $display("FAIL illegal_word%0d got=%h@%0d required=%h@%0d",
            i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
        end
      end
    end
    checks++;
    if (err_illegal !== 1'b1 || done !== 1'b1) begin
      failures++;
      $display("FAIL illegal_flag err=%b done=%b required=1/1",
        err_illegal, done);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops[9] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08,
                           6'h23, 6'h2B, 6'h3F, 6'h11};
    int len;
    for (int s = 0; s < 4; s++) begin
      prog.delete();
      len = int'($urandom_range(5, 14));
      for (int i = 0; i < len; i++)
        prog.push_back(mk(ops[$urandom_range(0, 8)],
          5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
          6'($urandom), 16'($urandom), 26'($urandom), i == len - 1));
      run_prog(2, 256);
      checks++;
      if (got_data.size() != exp_data.size() || spurious != 0) begin
        failures++;
        $display("FAIL rand%0d_count got=%0d required=%0d",
          s, got_data.size(), exp_data.size());
      end else begin
        for (int i = 0; i < exp_data.size(); i++) begin
          checks++;
          if (got_addr[i] != exp_addr[i] ||
              got_data[i] !== exp_data[i]) begin
            failures++;
            $display("FAIL rand%0d_word%0d got=%h@%0d required=%h@%0d",
              s, i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
          end
        end
      end
      checks++;
      if ({done, overflow, err_illegal} !== {exp_done, exp_ovf, exp_err}) begin
        failures++;
        $display("FAIL rand%0d_flags got=%b required=%b", s,
          {done, overflow, err_illegal}, {exp_done, exp_ovf, exp_err});
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      checks++;
      if (checksum !== exp_sum) begin
        failures++;
        $display("FAIL rand%0d_checksum got=%h required=%h",
          s, checksum, exp_sum);
      end
`endif
    end
  endtask

  task automatic test_overflow();
    logic [5:0] lops[7] = '{6'h00, 6'h02, 6'h04, 6'h05,
                            6'h08, 6'h23, 6'h2B};
    prog.delete();
    for (int i = 0; i < 257; i++)
      prog.push_back(mk(lops[$urandom_range(0, 6)],
        5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
        6'($urandom), 16'($urandom), 26'($urandom), 0));
    run_prog(0, 256);
    checks++;
    if (got_data.size() != 256) begin
      failures++;
      $display("FAIL ovf_count got=%0d required=256", got_data.size());
    end else begin
      for (int i = 0; i < 256; i++) begin
        checks++;
        if (got_addr[i] != exp_addr[i] || got_data[i] !== exp_data[i]) begin
          failures++;
          $display("FAIL ovf_word%0d got=%h@%0d required=%h@%0d",
            i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
        end
      end
      checks++;
      if (got_cyc[255] - got_cyc[0] != 255) begin
        failures++;
        $display("FAIL ovf_b2b span=%0d required=255",
          got_cyc[255] - got_cyc[0]);
      end
    end
    checks++;
    if (overflow !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ovf_flags ovf=%b done=%b busy=%b required=1/1/0",
        overflow, done, busy);
    end
    drive(prog[256]);
    in_valid = 1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL ovf_ready got=%b required=0", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (got_data.size() != 256) begin
      failures++;
      $display("FAIL ovf_extra got=%0d required=256", got_data.size());
    end
  endtask

  task automatic test_rst_mid();
    desc_t d;
    prog.delete();
    prog.push_back(mk(6'h08, 1, 1, 0, 0, 0, 16'h0011, 0, 0));
    prog.push_back(mk(6'h08, 2, 2, 0, 0, 0, 16'h0022, 0, 0));
    pulse_start();
    send(prog[0], 0);
    send(prog[1], 0);
    d = mk(6'h08, 3, 3, 0, 0, 0, 16'h0033, 0, 0);
    drive(d);
    in_valid = 1;
    @(posedge clk);
    #3 rst = 1;
    #1;
    checks++;
    if ({imem_we, busy, done, overflow, err_illegal, in_ready} !== 6'b0 ||
        imem_addr !== 8'd0 || imem_wdata !== 32'd0) begin
      failures++;
      $display("FAIL rstmid_out we=%b busy=%b rdy=%b addr=%h required=0",
        imem_we, busy, in_ready, imem_addr);
    end
    @(posedge clk); #1;
    rst = 0;
    in_valid = 0;
    checks++;
    if (got_data.size() != 2) begin
      failures++;
      $display("FAIL rstmid_writes got=%0d required=2", got_data.size());
    end
    prog.delete();
    prog.push_back(mk(6'h2B, 5, 6, 0, 0, 0, 16'h0040, 0, 1));
    run_prog(0, 256);
    checks++;
    if (got_data.size() != 1 || got_addr[0] != 0 ||
        got_data[0] !== exp_data[0]) begin
      failures++;
      $display("FAIL rstmid_restart n=%0d required=1 at addr 0",
        got_data.size());
    end
  endtask

  task automatic test_done_start();
    desc_t d;
    bit ok;
    logic [31:0] w;
    d = mk(6'h08, 7, 8, 0, 0, 0, 16'h0abc, 0, 1);
    w = enc(d, ok);
    got_addr.delete(); got_data.delete(); got_cyc.delete();
    start = 1;
    drive(d);
    in_valid = 1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL dstart_ready rdy=%b done=%b required=0/1",
        in_ready, done);
    end
    @(posedge clk); #1;
    start = 0;
    checks++;
    if (done !== 1'b0 || imem_we !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL dstart_clear done=%b we=%b busy=%b required=0/0/1",
        done, imem_we, busy);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL dstart_ready2 got=%b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 0;
    checks++;
    if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_wdata !== w) begin
      failures++;
      $display("FAIL dstart_write we=%b got=%h@%h required=%h@00",
        imem_we, imem_wdata, imem_addr, w);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_program();
    test_toggle();
    test_illegal();
    test_random();
    test_overflow();
    test_rst_mid();
    test_done_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout sim_time=%0t limit=2000000", $time);
    $fatal(1);
  end

endmodule
